// File: rtl/qos_wrr_sched.sv
// qos_wrr_sched: four-VC weighted round-robin FIFO read scheduler.
// Each VC owns a 3-bit weight (0 = disabled, 1-7 = pops per turn). A grant in
// IDLE loads the turn credit; SERVE pops the granted VC until the credit runs
// out or it goes empty/paused, then one IDLE bubble re-arbitrates from VC_id+1.
// Optional feature macro: QOS_WRR_PAUSE_EN (enables the per-VC pause input).
module qos_wrr_sched (
  input  logic       CLK_2MHz,
  input  logic       reset,
  input  logic       edit_weight,
  input  logic [1:0] vc_assign,
  input  logic [2:0] weight_assign,
  input  logic [3:0] empty,
  input  logic [3:0] pause,
  output logic [3:0] pop,
  output logic [1:0] VC_id,
  output logic [2:0] weight,
  output logic [2:0] credit,
  output logic       idle,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_SERVE = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      vc_q, vc_d;
  logic [2:0]      credit_q, credit_d;
  logic [3:0][2:0] weight_q, weight_d;

  logic [3:0] pause_eff;
  logic [3:0] eligible;
  logic [3:0] rot;
  logic [1:0] offset;
  logic [1:0] pick;
  logic       found;
  logic       serve_pop;

`ifdef QOS_WRR_PAUSE_EN
  assign pause_eff = pause;
`else
  // Pause is kept on the port for drop-in compatibility but has no effect.
  logic unused_pause;
  assign unused_pause = ^pause;
  assign pause_eff    = 4'b0000;
`endif

  // A VC can win arbitration only if it has data, a non-zero weight and no pause.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eligible[i] = ~empty[i] & (weight_q[i] != 3'd0) & ~pause_eff[i];
    end
  end

  // Rotate eligibility so bit 0 is the VC at ptr, then take the first set bit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rot    = eligible;
    offset = 2'd0;
    case (ptr_q)
      2'd0: rot = eligible;
      2'd1: rot = {eligible[0],   eligible[3:1]};
      2'd2: rot = {eligible[1:0], eligible[3:2]};
      2'd3: rot = {eligible[2:0], eligible[3]};
      default: rot = eligible;
    endcase
    if      (rot[0]) offset = 2'd0;
    else if (rot[1]) offset = 2'd1;
    else if (rot[2]) offset = 2'd2;
    else if (rot[3]) offset = 2'd3;
    found = |rot;
    pick  = ptr_q + offset;
  end

  // The granted VC is read whenever it has data and is not paused; the stored
  // weight is deliberately not consulted during the turn.
  always_comb begin
    serve_pop = (state_q == ST_SERVE) & ~empty[vc_q] & ~pause_eff[vc_q];
    pop       = serve_pop ? (4'b0001 << vc_q) : 4'b0000;
  end

  // Next-state logic for the grant FSM, credit counter and weight registers.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    vc_d     = vc_q;
    credit_d = credit_q;
    weight_d = weight_q;

    // The grant below reads weight_q, so a same-cycle write only affects the
    // next grant of that VC.
    if (edit_weight) begin
      weight_d[vc_assign] = weight_assign;
    end

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          vc_d     = pick;
          credit_d = weight_q[pick];
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // credit <= 1 rather than == 1 so a corrupted zero credit cannot wrap.
        if (serve_pop && (credit_q > 3'd1)) begin
          credit_d = credit_q - 3'd1;
        end else begin
          credit_d = 3'd0;
          ptr_d    = vc_q + 2'd1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        credit_d = 3'd0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK_2MHz) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others.
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      vc_q     <= 2'd0;
      credit_q <= 3'd0;
      // NOTE: the weight table is small and has a defined power-on value, so it
      // is reset like ordinary flops; a larger RAM-style table would not be.
      weight_q <= {4{3'd1}};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      vc_q     <= vc_d;
      credit_q <= credit_d;
      weight_q <= weight_d;
    end
  end

  assign VC_id  = vc_q;
  assign weight = weight_q[vc_q];
  assign credit = credit_q;
  assign State  = state_q;
  assign idle   = (state_q == ST_IDLE) & ~|eligible;

endmodule

// File: tb/tb_qos_wrr_sched.sv
// Bench for qos_wrr_sched. Each scenario pushes its expected
// {idle, State, VC_id, credit, pop} per cycle into a scoreboard queue as the
// stimulus for that cycle is applied, and pops/compares once outputs settle.
`timescale 1ns / 1ps
module tb_qos_wrr_sched;

  localparam logic [1:0] I = 2'b01;
  localparam logic [1:0] S = 2'b10;

  logic       clk;
  logic       reset;
  logic       edit_weight;
  logic [1:0] vc_assign;
  logic [2:0] weight_assign;
  logic [3:0] empty;
  logic [3:0] pause;
  logic [3:0] pop;
  logic [1:0] VC_id;
  logic [2:0] weight;
  logic [2:0] credit;
  logic       idle;
  logic [1:0] State;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q [$];

  qos_wrr_sched dut (
    .CLK_2MHz      (clk),
    .reset         (reset),
    .edit_weight   (edit_weight),
    .vc_assign     (vc_assign),
    .weight_assign (weight_assign),
    .empty         (empty),
    .pause         (pause),
    .pop           (pop),
    .VC_id         (VC_id),
    .weight        (weight),
    .credit        (credit),
    .idle          (idle),
    .State         (State)
  );

  initial begin
    clk = 1'b0;
    forever #250 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] ex(input int id, input logic [1:0] st,
                                     input int vc, input int cr, input logic [3:0] p);
    return {1'(id), st, 2'(vc), 3'(cr), p};
  endfunction

  // Bubble cycle: IDLE, credit 0, no pop, some VC still eligible.
  function automatic logic [11:0] iw(input int vc);
    return ex(0, I, vc, 0, 4'b0000);
  endfunction

  // Serve cycle popping the granted VC with the given remaining credit.
  function automatic logic [11:0] sv(input int vc, input int cr);
    logic [3:0] p;
    p = 4'b0001 << vc;
    return ex(0, S, vc, cr, p);
  endfunction

  function automatic logic [11:0] observed();
    return {idle, State, VC_id, credit, pop};
  endfunction

  task automatic do_reset();
    reset         = 1'b0;
    edit_weight   = 1'b0;
    vc_assign     = 2'd0;
    weight_assign = 3'd0;
    empty         = 4'hF;
    pause         = 4'h0;
    repeat (2) @(negedge clk);
  endtask

  // Releases reset (if held) and writes one weight while all FIFOs are empty.
  task automatic write_weight(input logic [1:0] vc, input logic [2:0] w);
    @(negedge clk);
    reset         = 1'b1;
    empty         = 4'hF;
    edit_weight   = 1'b1;
    vc_assign     = vc;
    weight_assign = w;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    #1;
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b required 1", idle); end
    checks++;
    if (State !== I) begin errors++; $display("FAIL reset_state: got %b required %b", State, I); end
    checks++;
    if (pop !== 4'b0000) begin errors++; $display("FAIL reset_pop: got %b required 0000", pop); end
    checks++;
    if (credit !== 3'd0) begin errors++; $display("FAIL reset_credit: got %0d required 0", credit); end
    checks++;
    if (VC_id !== 2'd0) begin errors++; $display("FAIL reset_vc: got %0d required 0", VC_id); end
    checks++;
    if (weight !== 3'd1) begin errors++; $display("FAIL reset_weight: got %0d required 1", weight); end
    // Data arriving while reset is held must not start a turn.
    empty = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({State, pop} !== {I, 4'b0000}) begin
      errors++;
      $display("FAIL reset_hold: got state %b pop %b required state %b pop 0000", State, pop, I);
    end
  endtask

  task automatic test_default_rr();
    logic [11:0] tbl [10];
    logic [11:0] got, want;
    tbl = '{iw(0), sv(0,1), iw(0), sv(1,1), iw(1), sv(2,1), iw(2), sv(3,1), iw(3), sv(0,1)};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      reset = 1'b1; edit_weight = 1'b0; empty = 4'h0;
      exp_q.push_back(tbl[k]);
      #1;
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL default_rr cycle %0d: got %b required %b", k, got, want); end
    end
  endtask

  task automatic test_weighted();
    logic [11:0] tbl [20];
    logic [11:0] got, want;
    tbl = '{iw(0), sv(0,3), sv(0,2), sv(0,1), iw(0), sv(1,1), iw(1), sv(3,2), sv(3,1), iw(3),
            sv(0,3), sv(0,2), sv(0,1), iw(0), sv(1,1), iw(1), sv(3,2), sv(3,1), iw(3), sv(0,3)};
    do_reset();
    write_weight(2'd0, 3'd3);
    write_weight(2'd1, 3'd1);
    write_weight(2'd2, 3'd0);
    write_weight(2'd3, 3'd2);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      edit_weight = 1'b0; empty = 4'h0;
      exp_q.push_back(tbl[k]);
      #1;
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL weighted cycle %0d: got %b required %b", k, got, want); end
    end
  endtask

  task automatic test_empty_end();
    logic [11:0] tbl [12];
    logic [11:0] got, want;
    tbl = '{iw(0), sv(0,5), sv(0,4), ex(0, S, 0, 3, 4'b0000), iw(0), sv(1,1), iw(1),
            sv(2,1), iw(2), sv(3,1), iw(3), sv(1,1)};
    do_reset();
    write_weight(2'd0, 3'd5);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      edit_weight = 1'b0;
      empty = (k < 3) ? 4'b0000 : 4'b0001;
      exp_q.push_back(tbl[k]);
      #1;
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL empty_end cycle %0d: got %b required %b", k, got, want); end
    end
  endtask

  task automatic test_pause();
    logic [11:0] tbl [10];
    logic [11:0] got, want;
`ifdef QOS_WRR_PAUSE_EN
    tbl = '{iw(0), sv(0,1), iw(0), sv(2,1), iw(2), sv(3,1), iw(3), sv(0,1), iw(0), sv(2,1)};
`else
    tbl = '{iw(0), sv(0,1), iw(0), sv(1,1), iw(1), sv(2,1), iw(2), sv(3,1), iw(3), sv(0,1)};
`endif
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      reset = 1'b1; edit_weight = 1'b0; empty = 4'h0; pause = 4'b0010;
      exp_q.push_back(tbl[k]);
      #1;
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL pause cycle %0d: got %b required %b", k, got, want); end
    end
    pause = 4'h0;
  endtask

  task automatic test_edit_in_service();
    logic [11:0] tbl [21];
    logic [11:0] got, want;
    tbl = '{iw(0), sv(0,1), iw(0), sv(1,1), iw(1), sv(2,1), iw(2), sv(3,1), iw(3),
            sv(0,4), sv(0,3), sv(0,2), sv(0,1), iw(0), sv(1,1), iw(1), sv(2,1), iw(2),
            sv(3,1), iw(3), sv(1,1)};
    do_reset();
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      reset = 1'b1; empty = 4'h0;
      edit_weight   = (k == 0) || (k == 9);
      vc_assign     = 2'd0;
      weight_assign = (k == 0) ? 3'd4 : 3'd0;
      exp_q.push_back(tbl[k]);
      #1;
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL edit_in_service cycle %0d: got %b required %b", k, got, want); end
      if (k == 1) begin
        checks++;
        if (weight !== 3'd4) begin errors++; $display("FAIL edit_same_grant_weight: got %0d required 4", weight); end
      end
      if (k == 10) begin
        checks++;
        if (weight !== 3'd0) begin errors++; $display("FAIL edit_during_turn_weight: got %0d required 0", weight); end
      end
    end
  endtask

  task automatic test_reset_mid_turn();
    logic [11:0] tbl [15];
    logic [11:0] got, want;
    tbl = '{iw(0), sv(0,1), iw(0), sv(1,1), iw(1), sv(2,3), sv(2,2), iw(0), iw(0),
            sv(0,1), iw(0), sv(1,1), iw(1), sv(2,1), iw(2)};
    do_reset();
    write_weight(2'd2, 3'd3);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      empty         = 4'h0;
      reset         = !((k == 6) || (k == 7));
      edit_weight   = (k == 6) || (k == 7);
      vc_assign     = 2'd2;
      weight_assign = 3'd7;
      exp_q.push_back(tbl[k]);
      #1;
      got = observed(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL reset_mid_turn cycle %0d: got %b required %b", k, got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_default_rr();
    test_weighted();
    test_empty_end();
    test_pause();
    test_edit_in_service();
    test_reset_mid_turn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qos_wrr_sched.md
QOS_WRR_SCHED -- requirements
Module: qos_wrr_sched

Interface
REQ-001 SHALL have parameter-free ports; clock and reset first: CLK_2MHz  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have reset  in  1  synchronous, active-low; sampled on the CLK_2MHz rising edge.
REQ-003 SHALL have edit_weight  in  1  weight write strobe.
REQ-004 SHALL have vc_assign  in  2  target VC of a weight write.
REQ-005 SHALL have weight_assign  in  3  new weight, 0 = VC disabled, 1-7 = pops per turn.
REQ-006 SHALL have empty  in  4  per-VC FIFO empty flags.
REQ-007 SHALL have pause  in  4  per-VC downstream pause (see Configuration).
REQ-008 SHALL have pop  out  4  one-hot FIFO read strobe, at most one bit high.
REQ-009 SHALL have VC_id  out  2  currently granted VC.
REQ-010 SHALL have weight  out  3  stored weight of VC_id.
REQ-011 SHALL have credit  out  3  remaining pops in current turn.
REQ-012 SHALL have idle  out  1  high in IDLE with no eligible VC.
REQ-013 SHALL have State  out  2  FSM state, IDLE=2'b01, SERVE=2'b10.

Function
REQ-014 SHALL hold four 3-bit weight registers; edit_weight=1 writes weight_assign to weight[vc_assign] at the clock edge.
REQ-015 SHALL define eligible[i] = ~empty[i] & (weight[i]!=0) & ~pause_eff[i].
REQ-016 SHALL keep a 2-bit round-robin pointer ptr; search order ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-017 In IDLE with any eligible VC: latch VC_id = first eligible in search order, load credit = weight[VC_id] (pre-write value), go to SERVE; pop stays 0 this cycle.
REQ-018 In IDLE with no eligible VC: stay in IDLE, idle=1, pop=0.
REQ-019 In SERVE: pop[VC_id] = ~empty[VC_id] & ~pause_eff[VC_id] (combinational); weight value ignored during the turn.
REQ-020 Each cycle pop is high, credit SHALL decrement by 1.
REQ-021 Turn ends when (pop high and credit==1) or pop low in SERVE; then ptr <= VC_id+1 (2-bit wrap 3->0), state <= IDLE.
REQ-022 Grant-to-first-pop latency SHALL be exactly 1 cycle; one bubble cycle (IDLE) between turns.
REQ-023 Weight write to the VC in service SHALL NOT alter credit; new weight applies from its next grant, including weight 0.
REQ-024 Simultaneous edit_weight and grant of the same VC: grant uses old weight.
REQ-025 credit SHALL never underflow; credit is 0 in IDLE.

Reset
REQ-026 On reset=0 at a clock edge: State=IDLE, ptr=0, VC_id=0, credit=0, pop=0, all weights=3'd1; idle follows REQ-012 combinationally.
REQ-027 Reset asserted mid-turn SHALL abort the turn with no further pop from the next cycle; edit_weight ignored while reset=0.

Configuration
REQ-028 Macro QOS_WRR_PAUSE_EN defined: pause_eff = pause; a paused VC is skipped in IDLE and ends the turn in SERVE (pop low).
REQ-029 Macro QOS_WRR_PAUSE_EN undefined: pause_eff = 4'b0000; pause port kept but ignored.

Verification
REQ-030 Reset, all empty=4'b1111 -> idle=1, State=IDLE, pop=0, weight=3'd1 for every VC.
REQ-031 Default weights, empty=4'b0000 held -> pop sequence 0001,-,0010,-,0100,-,1000,-,0001 (- = bubble).
REQ-032 Weights {3,1,0,2} for VC0..3, all non-empty -> per round VC0 popped 3 cycles, VC1 1, VC2 skipped, VC3 2; credit counts 3,2,1.
REQ-033 VC0 weight 5, empty[0] rises after 2 pops -> turn ends, ptr=1, next grant VC1, pop never high with empty[0]=1.
REQ-034 QOS_WRR_PAUSE_EN defined, pause=4'b0010, all non-empty -> VC1 never popped; undefined -> VC1 popped normally.
REQ-035 reset=0 during VC2 turn with credit=2 -> next cycle pop=0, credit=0, weights back to 1, next grant after release is VC0.
